fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the program memory. Owns the program counter and drives the memory address.
- Captures the combinationally-returned instruction into an IF/ID holding register with a valid/ready handshake toward decode.
- Handles branch/jump redirects, flushes the held instruction on redirect, and traps fetches that are misaligned or outside the text segment.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage in front of the program memory.
// Owns the PC and drives Address_o. The word that comes back is captured
// into an IF/ID holding register, which hands off to decode through a
// valid/ready handshake. Redirects flush the held instruction. A fetch that
// is misaligned or outside the text segment sends the stage into a sticky
// FAULT state.
// Optional feature: define FETCH_PERF_CNT_EN to build the fetch/stall
// performance counters. Without it, both counter ports read 0.

module fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Branch_Taken_i,
  input  logic [DATA_WIDTH-1:0] Branch_Target_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Decode_Ready_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PC_Plus4_o,
  output logic                  Valid_o,
  output logic                  Fault_o,
  output logic [DATA_WIDTH-1:0] Fault_Addr_o,
  output logic [31:0]           Fetch_Count_o,
  output logic [31:0]           Stall_Count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h00000013);

  // Upper bound of the legal window, one bit wider so the end address cannot wrap.
  localparam logic [DATA_WIDTH:0] WINDOW_END =
    {1'b0, RESET_PC} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic                  valid_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] fault_addr_q;

  logic [DATA_WIDTH-1:0] pc_next4;
  logic                  next4_legal;
  logic                  target_legal;
  logic                  slot_free;

  // Unsigned window test: RESET_PC <= a < RESET_PC + 4*MEMORY_DEPTH.
  function automatic logic in_window(input logic [DATA_WIDTH-1:0] a);
    return (a >= RESET_PC) && ({1'b0, a} < WINDOW_END);
  endfunction

  assign pc_next4     = pc + DATA_WIDTH'(4);
  assign next4_legal  = in_window(pc_next4);
  assign target_legal = (Branch_Target_i[1:0] == 2'b00) && in_window(Branch_Target_i);
  assign slot_free    = !valid_q || Decode_Ready_i;

  // Fetch control: reset, then the IDLE/RUN/FAULT sequencing of PC and the IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
        end
        RUN: begin
          if (Branch_Taken_i) begin
            valid_q <= 1'b0;
            if (target_legal) begin
              pc <= Branch_Target_i;
            end else begin
              state        <= FAULT;
              fault_q      <= 1'b1;
              fault_addr_q <= Branch_Target_i;
            end
          end else if (slot_free) begin
            instr_q <= Instruction_i;
            pc_q    <= pc;
            valid_q <= 1'b1;
            if (next4_legal) begin
              pc <= pc_next4;
            end else begin
              state        <= FAULT;
              fault_q      <= 1'b1;
              fault_addr_q <= pc_next4;
            end
          end
        end
        FAULT: begin
          if (valid_q && Decode_Ready_i) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Address_o     = pc;
  assign Instruction_o = instr_q;
  assign PC_o          = pc_q;
  assign PC_Plus4_o    = pc_q + DATA_WIDTH'(4);
  assign Valid_o       = valid_q;
  assign Fault_o       = fault_q;
  assign Fault_Addr_o  = fault_addr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  // Performance counters: accepted hand-offs and back-pressured cycles; both wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (valid_q && Decode_Ready_i && !Branch_Taken_i) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (valid_q && !Decode_Ready_i) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign Fetch_Count_o = fetch_cnt;
  assign Stall_Count_o = stall_cnt;
`else
  assign Fetch_Count_o = 32'd0;
  assign Stall_Count_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. A behavioural ROM returns a
// word derived from the address. Each step is checked against
// hand-computed values.

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h00400000;
  localparam logic [31:0] NOP      = 32'h00000013;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [31:0] EXP_FETCH = 32'd5;
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_FETCH = 32'd0;
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic        decode_ready;
  logic [31:0] address;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .Branch_Taken_i (branch_taken),
    .Branch_Target_i(branch_target),
    .Instruction_i  (instruction),
    .Decode_Ready_i (decode_ready),
    .Address_o      (address),
    .Instruction_o  (instr_out),
    .PC_o           (pc_out),
    .PC_Plus4_o     (pc_plus4),
    .Valid_o        (valid),
    .Fault_o        (fault),
    .Fault_Addr_o   (fault_addr),
    .Fetch_Count_o  (fetch_count),
    .Stall_Count_o  (stall_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Program memory model: each word is a fixed pattern XORed with its address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hA5000000 ^ a;
  endfunction

  assign instruction = rom(address);

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic br, input logic [31:0] tgt,
                               input logic rdy, input logic rst);
    branch_taken  = br;
    branch_target = tgt;
    decode_ready  = rdy;
    reset         = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_addr"},   address,            RESET_PC);
    checkOutput({tag, "_valid"},  {31'd0, valid},     32'd0);
    checkOutput({tag, "_instr"},  instr_out,          NOP);
    checkOutput({tag, "_pc"},     pc_out,             RESET_PC);
    checkOutput({tag, "_pc4"},    pc_plus4,           32'h00400004);
    checkOutput({tag, "_fault"},  {31'd0, fault},     32'd0);
    checkOutput({tag, "_faddr"},  fault_addr,         32'd0);
    checkOutput({tag, "_fcnt"},   fetch_count,        32'd0);
    checkOutput({tag, "_scnt"},   stall_count,        32'd0);
  endtask

  initial begin
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    decode_ready  = 1'b0;
    reset         = 1'b1;

    // Reset
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    checkReset("reset0");

    // IDLE cycle: no capture
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("idle_valid", {31'd0, valid}, 32'd0);
    checkOutput("idle_addr",  address,        32'h00400000);

    // Sequential fetch
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("seq0_valid", {31'd0, valid}, 32'd1);
    checkOutput("seq0_pc",    pc_out,         32'h00400000);
    checkOutput("seq0_instr", instr_out,      rom(32'h00400000));
    checkOutput("seq0_addr",  address,        32'h00400004);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("seq1_pc",    pc_out,         32'h00400004);
    checkOutput("seq1_addr",  address,        32'h00400008);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("seq2_pc",    pc_out,         32'h00400008);
    checkOutput("seq2_instr", instr_out,      rom(32'h00400008));
    checkOutput("seq2_pc4",   pc_plus4,       32'h0040000C);

    // Stall for 3 cycles: everything holds
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("stall_valid", {31'd0, valid}, 32'd1);
      checkOutput("stall_pc",    pc_out,         32'h00400008);
      checkOutput("stall_instr", instr_out,      rom(32'h00400008));
      checkOutput("stall_addr",  address,        32'h0040000C);
    end

    // Release: next word follows immediately
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("rel0_pc",    pc_out,    32'h0040000C);
    checkOutput("rel0_instr", instr_out, rom(32'h0040000C));
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("rel1_pc",    pc_out,    32'h00400010);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("rel2_pc",    pc_out,    32'h00400014);
    checkOutput("rel2_addr",  address,   32'h00400018);
    checkOutput("perf_fetch", fetch_count, EXP_FETCH);
    checkOutput("perf_stall", stall_count, EXP_STALL);

    // Redirect while stalled with a live instruction
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("pre_br_pc",  pc_out, 32'h00400014);
    applyStimulus(1'b1, 32'h00400040, 1'b0, 1'b0);
    checkOutput("br_valid",   {31'd0, valid}, 32'd0);
    checkOutput("br_addr",    address,        32'h00400040);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("br_cap_valid", {31'd0, valid}, 32'd1);
    checkOutput("br_cap_pc",    pc_out,         32'h00400040);
    checkOutput("br_cap_instr", instr_out,      rom(32'h00400040));
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("br_next_pc",   pc_out,         32'h00400044);
    checkOutput("br_next_addr", address,        32'h00400048);

    // Misaligned redirect target causes a fault
    applyStimulus(1'b1, 32'h00400042, 1'b1, 1'b0);
    checkOutput("mis_fault", {31'd0, fault}, 32'd1);
    checkOutput("mis_faddr", fault_addr,     32'h00400042);
    checkOutput("mis_valid", {31'd0, valid}, 32'd0);
    checkOutput("mis_addr",  address,        32'h00400048);

    // PC frozen and redirects ignored while in FAULT
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], RESET_PC, i[1], 1'b0);
      checkOutput("frz_addr",  address,        32'h00400048);
      checkOutput("frz_valid", {31'd0, valid}, 32'd0);
      checkOutput("frz_fault", {31'd0, fault}, 32'd1);
      checkOutput("frz_faddr", fault_addr,     32'h00400042);
    end

    // Reset in the middle of a fault
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkReset("reset1");

    // Run-off at the end of the text segment
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ro_first_pc", pc_out, 32'h00400000);
    applyStimulus(1'b1, 32'h00400070, 1'b1, 1'b0);
    checkOutput("ro_br_addr",  address, 32'h00400070);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ro_pc70",     pc_out,  32'h00400070);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ro_pc78",     pc_out,  32'h00400078);
    checkOutput("ro_addr7c",   address, 32'h0040007C);
    checkOutput("ro_nofault",  {31'd0, fault}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ro_last_pc",    pc_out,         32'h0040007C);
    checkOutput("ro_last_instr", instr_out,      rom(32'h0040007C));
    checkOutput("ro_last_valid", {31'd0, valid}, 32'd1);
    checkOutput("ro_fault",      {31'd0, fault}, 32'd1);
    checkOutput("ro_faddr",      fault_addr,     32'h00400080);
    checkOutput("ro_addr_hold",  address,        32'h0040007C);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("ro_held_valid", {31'd0, valid}, 32'd1);
    checkOutput("ro_held_pc",    pc_out,         32'h0040007C);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ro_drained",    {31'd0, valid}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("ro_no_capture", {31'd0, valid}, 32'd0);
    checkOutput("ro_addr_frz",   address,        32'h0040007C);

    // Reset again, then a redirect just past the window end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    checkReset("reset2");
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00400080, 1'b1, 1'b0);
    checkOutput("hi_fault", {31'd0, fault}, 32'd1);
    checkOutput("hi_faddr", fault_addr,     32'h00400080);
    checkOutput("hi_addr",  address,        32'h00400000);
    checkOutput("hi_valid", {31'd0, valid}, 32'd0);

    // Reset again, then a redirect just below the window start
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h003FFFFC, 1'b1, 1'b0);
    checkOutput("lo_fault", {31'd0, fault}, 32'd1);
    checkOutput("lo_faddr", fault_addr,     32'h003FFFFC);
    checkOutput("lo_addr",  address,        32'h00400000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
